clint_timer: RTL
================

# clint_timer

Memory-mapped machine timer (CLINT subset) that supplies the CSR file with `mtime_i` and `timer_interrupt`. It holds the 64-bit `mtime` counter and the `mtimecmp` compare register. Both are exposed to the data-memory bus as four 32-bit words. The block sits on the peripheral side of the load/store path, and its outputs wire directly into the CSR register file.

## Interface
Parameters:
- `TICK_DIV`, default 1: `clk` cycles per `mtime` increment. Must be ≥1; 1 means increment every cycle.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `bus_req`  in  1  access request. The initiator holds it until `bus_ack`.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  4  byte offset. Only 0x0, 0x4, 0x8 and 0xC are decoded; bits [1:0] are ignored.
- `bus_wdata`  in  32  write data.
- `bus_be`  in  4  byte enables for writes.
- `bus_rdata`  out  32  read data, valid while `bus_ack`=1.
- `bus_ack`  out  1  one-cycle completion pulse.
- `mtime_o`  out  64  current `mtime`, connected to the CSR file's `mtime_i`.
- `timer_interrupt`  out  1  registered `mtime >= mtimecmp`.

## Operation
- Register map, defined by word offset:
  - 0x0 `MTIME_LO`
  - 0x4 `MTIME_HI`
  - 0x8 `MTIMECMP_LO`
  - 0xC `MTIMECMP_HI`
- Undecoded offsets read as 0 and ignore writes, but are still acked.
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt fires out of reset.
  - Prescaler = 0.
  - `bus_ack` = 0, `bus_rdata` = 0, `timer_interrupt` = 0.
  - Snapshot register = 0.
- Prescaler:
  - Counts 0 to `TICK_DIV-1`; `tick` is asserted in the cycle the count equals `TICK_DIV-1`, then the count returns to 0.
  - With `TICK_DIV`=1, `tick` is constant 1.
- `mtime` update:
  - Increments by 1 when `tick` is asserted. The counter is 64 bits with full carry and wraps from 2^64-1 to 0.
- Writes:
  - Byte-merged per `bus_be` into the addressed half.
  - A write to either `mtime` half in the same cycle as `tick` wins: the written half takes the merged data, the other half holds, and there is no increment or carry that cycle.
  - A write to `mtime` does not reset the prescaler.
- Coherent 64-bit read:
  - A read of `MTIME_LO` returns the live low word and captures the live `mtime[63:32]` into the snapshot register.
  - A read of `MTIME_HI` returns the snapshot value, not the live value.
  - Software reads LO then HI.
  - `MTIMECMP` reads return the live register.
- Interrupt:
  - `timer_interrupt` is registered from an unsigned 64-bit compare of the current `mtime` and `mtimecmp` register values.
  - It stays level-high until `mtimecmp` is raised above `mtime` or `mtime` wraps.
  - There is no sticky pending bit; masking belongs to the CSR file.
- Bus handshake FSM:
  - State `IDLE`: if `bus_req` is asserted, perform the read/write and go to `ACK`.
  - State `ACK`: `bus_ack`=1 and `bus_rdata` valid; always return to `IDLE`.
  - `bus_req` is ignored while in `ACK`, so the maximum rate is one access per 2 cycles.
  - `bus_rdata` is 0 for writes.

## Timing
- Access latency:
  - `bus_req` sampled at edge N; the write takes effect at edge N.
  - `bus_ack` and `bus_rdata` are high during cycle N+1 and fall at N+2.
- `timer_interrupt` lags the registers by one cycle: the edge that makes `mtime == mtimecmp` is followed one edge later by `timer_interrupt`=1.
- A write to `mtimecmp` at edge N clears/sets `timer_interrupt` at edge N+1.
- `mtime_o` is the register itself, with no extra delay.
- Reset mid-transaction:
  - All state returns to reset values asynchronously and the FSM returns to `IDLE`.
  - The pending ack is dropped; the initiator must reissue.

## Structure
- Shared package `defines.sv`:
  - `CLINT_MTIME_LO`/`HI`, `CLINT_MTIMECMP_LO`/`HI` offset constants.
  - `clint_state_t` enum {`IDLE`, `ACK`}.
- Sub-module `clint_prescaler` (`TICK_DIV` parameter, outputs `tick`); everything else stays in `clint_timer`.
- Byte-merge is a local function.

## Test plan
- Reset release with `TICK_DIV`=1 → `mtime_o` reads 1, 2, 3 on consecutive edges; `timer_interrupt`=0; `MTIMECMP_HI` read returns FFFF_FFFF with `bus_ack` exactly one cycle after the req edge.
- Write `MTIMECMP_LO`=0x10 and `MTIMECMP_HI`=0, with `mtime` running from 0 → `timer_interrupt` rises the edge after `mtime` reaches 0x10. Then write `MTIMECMP_LO`=0xFFFF_FFFF → `timer_interrupt` falls on the next edge.
- Write `MTIME_LO`=0xFFFF_FFFE and `MTIME_HI`=0 → after 2 ticks `mtime`=0x1_0000_0000 (carry). Read LO, then wait 10 cycles, then read HI → the HI read returns the snapshot taken at the LO read.
- `TICK_DIV`=4 → `mtime` increments every 4th cycle. A write to `MTIME_LO`=0x100 on a tick cycle → value is 0x100 (no increment), then 0x101 four cycles later.
- Write with `bus_be`=4'b0010 and data 0xAABBCCDD to `MTIMECMP_LO` (reset FFFF_FFFF) → readback FFFF_CCFF. Write to offset 0x3 (decoded as 0x0) → affects `MTIME_LO`.
- Assert `rst` in the `ACK` cycle → `bus_ack` drops immediately; `mtime`=0; `mtimecmp`=all ones. Hold `bus_req` high continuously → acks pulse every other cycle.

Source files
------------

// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: register offsets and bus FSM states shared by the CLINT timer
package clint_timer_pkg;
  localparam logic [3:0] CLINT_MTIME_LO    = 4'h0;
  localparam logic [3:0] CLINT_MTIME_HI    = 4'h4;
  localparam logic [3:0] CLINT_MTIMECMP_LO = 4'h8;
  localparam logic [3:0] CLINT_MTIMECMP_HI = 4'hC;
  typedef enum logic {IDLE, ACK} clint_state_t;
endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk into a one-cycle tick every TICK_DIV cycles
module clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(TICK_DIV - 1);
  // count up to TICK_DIV-1, wrap on tick (stays at 0 when TICK_DIV is 1)
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  // prescaler count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped mtime/mtimecmp with coherent 64-bit reads and timer interrupt
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_be,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [63:0] mtime_o,
  output logic        timer_interrupt
);
  clint_state_t state_q, state_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [31:0] snap_q, snap_d, rdata_q, rdata_d;
  logic        irq_q, irq_d, tick, acc, rd, wr;
  logic [1:0]  word;
  logic        unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = be[i] ? wd[8*i+:8] : old[8*i+:8];
    return m;
  endfunction

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (.clk(clk), .rst(rst), .tick(tick));

  assign unused_addr     = ^bus_addr[1:0];
  assign bus_ack         = state_q == ACK;
  assign bus_rdata       = rdata_q;
  assign mtime_o         = mtime_q;
  assign timer_interrupt = irq_q;

  // decode the access, apply writes (a write beats the tick), build read data and next state
  always_comb begin
    acc        = state_q == IDLE && bus_req;
    wr         = acc && bus_we;
    rd         = acc && !bus_we;
    word       = bus_addr[3:2];
    state_d    = acc ? ACK : IDLE;
    mtime_d    = wr && word == CLINT_MTIME_LO[3:2] ? {mtime_q[63:32], merge(mtime_q[31:0], bus_wdata, bus_be)} :
                 wr && word == CLINT_MTIME_HI[3:2] ? {merge(mtime_q[63:32], bus_wdata, bus_be), mtime_q[31:0]} :
                 tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = wr && word == CLINT_MTIMECMP_LO[3:2] ? {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], bus_wdata, bus_be)} :
                 wr && word == CLINT_MTIMECMP_HI[3:2] ? {merge(mtimecmp_q[63:32], bus_wdata, bus_be), mtimecmp_q[31:0]} :
                 mtimecmp_q;
    snap_d     = rd && word == CLINT_MTIME_LO[3:2] ? mtime_q[63:32] : snap_q;
    rdata_d    = !rd ? 32'd0 :
                 word == CLINT_MTIME_LO[3:2]    ? mtime_q[31:0] :
                 word == CLINT_MTIME_HI[3:2]    ? snap_q :
                 word == CLINT_MTIMECMP_LO[3:2] ? mtimecmp_q[31:0] : mtimecmp_q[63:32];
    irq_d      = mtime_q >= mtimecmp_q;
  end

  // state registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      snap_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      snap_q     <= snap_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
endmodule
